// File: rtl/pprm_stage_3_pipe.sv
// Final PPRM GF(2^8) inverter stage: two GF(2^4) products of A with D = inv(delta),
// wrapped in a two-register valid/ready pipeline that carries a sideband tag.

module pprm_gf16_mul (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [3:0] p_o
);
  // GF(4) in {p1,p0} = p1*w + p0 with w^2 = w + 1
  function automatic logic [1:0] gf4_mul(input logic [1:0] p, input logic [1:0] q);
    logic [1:0] r;
    r[1] = (p[1] & q[1]) ^ (p[1] & q[0]) ^ (p[0] & q[1]);
    r[0] = (p[1] & q[1]) ^ (p[0] & q[0]);
    return r;
  endfunction

  function automatic logic [1:0] gf4_phi(input logic [1:0] p);
    return {p[1] ^ p[0], p[1]};
  endfunction

  logic [1:0] hh, hl, lh, ll;

  assign hh = gf4_mul(a_i[3:2], b_i[3:2]);
  assign hl = gf4_mul(a_i[3:2], b_i[1:0]);
  assign lh = gf4_mul(a_i[1:0], b_i[3:2]);
  assign ll = gf4_mul(a_i[1:0], b_i[1:0]);

  // y^2 = y + phi folds the high-high term back into both halves
  assign p_o = {hh ^ hl ^ lh, gf4_phi(hh) ^ ll};
endmodule

module pprm_stage_3_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [3:0]       in_d,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_inv,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int NUM_LANES = 2;
  localparam int VEC_W     = 4;

  // vld_q[1] = S1 occupied, vld_q[2] = S2 (output) occupied
  logic [2:1]       vld_q, vld_d;
  logic [7:0]       s1_a_q, s1_a_d;
  logic [3:0]       s1_d_q, s1_d_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [7:0]       out_inv_q, out_inv_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic adv2, load1;
  logic [NUM_LANES-1:0][VEC_W-1:0] lane_x, lane_prod;

  // lane 1 -> high nibble A_h*D, lane 0 -> low nibble (A_h^A_l)*D
  assign lane_x[1] = s1_a_q[7:4];
  assign lane_x[0] = s1_a_q[7:4] ^ s1_a_q[3:0];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    pprm_gf16_mul u_mul (
      .a_i (lane_x[g]),
      .b_i (s1_d_q),
      .p_o (lane_prod[g])
    );
  end

  // Outputs are masked during reset so nothing transfers in the reset cycle
  assign out_valid = vld_q[2] & ~rst;
  assign adv2      = vld_q[1] & (~vld_q[2] | out_ready);
  assign in_ready  = ~rst & (~vld_q[1] | adv2);
  assign load1     = in_valid & in_ready;
  assign busy      = vld_q[1] | out_valid;
  assign out_inv   = out_inv_q;
  assign out_tag   = out_tag_q;

  always_comb begin
    vld_d     = vld_q;
    s1_a_d    = s1_a_q;
    s1_d_d    = s1_d_q;
    s1_tag_d  = s1_tag_q;
    out_inv_d = out_inv_q;
    out_tag_d = out_tag_q;

    vld_d[2] = adv2 | (vld_q[2] & ~out_ready);
    vld_d[1] = load1 | (vld_q[1] & ~adv2);

    if (adv2) begin
      out_inv_d = lane_prod;
      out_tag_d = s1_tag_q;
    end
    if (load1) begin
      s1_a_d   = in_a;
      s1_d_d   = in_d;
      s1_tag_d = in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q     <= '0;
      s1_a_q    <= '0;
      s1_d_q    <= '0;
      s1_tag_q  <= '0;
      out_inv_q <= '0;
      out_tag_q <= '0;
    end else begin
      vld_q     <= vld_d;
      s1_a_q    <= s1_a_d;
      s1_d_q    <= s1_d_d;
      s1_tag_q  <= s1_tag_d;
      out_inv_q <= out_inv_d;
      out_tag_q <= out_tag_d;
    end
  end
endmodule

// File: tb/tb_pprm_stage_3_pipe.sv
// Bench for pprm_stage_3_pipe: vector table, streaming/backpressure/reset sequences,
// random and exhaustive traffic against a log-table GF reference model.

module tb_pprm_stage_3_pipe;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_a;
  logic [3:0]       in_d;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_inv;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  pprm_stage_3_pipe #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_d(in_d), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inv(out_inv), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] inv; logic [TAG_W-1:0] tag; } exp_t;
  typedef struct { logic [7:0] a; logic [3:0] d; logic [7:0] exp; } vec_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic stall_prev = 1'b0;
  logic [7:0]       hold_inv;
  logic [TAG_W-1:0] hold_tag;

  // GF(4) nonzero elements are powers of w: 1=w^0, w=w^1, w+1=w^2
  function automatic int lg4(input logic [1:0] x);
    case (x)
      2'd1:    return 0;
      2'd2:    return 1;
      default: return 2;
    endcase
  endfunction

  function automatic logic [1:0] alog4(input int e);
    case (e % 3)
      0:       return 2'd1;
      1:       return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] m4(input logic [1:0] p, input logic [1:0] q);
    if (p == 2'd0 || q == 2'd0) return 2'd0;
    return alog4(lg4(p) + lg4(q));
  endfunction

  // (a1 y + a0)(b1 y + b0) as a polynomial, then reduce y^2 -> y + w
  function automatic logic [3:0] m16(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] c2, c1, c0;
    c2 = m4(a[3:2], b[3:2]);
    c1 = m4(a[3:2], b[1:0]) ^ m4(a[1:0], b[3:2]);
    c0 = m4(a[1:0], b[1:0]);
    return {c1 ^ c2, c0 ^ m4(c2, 2'd2)};
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] a, input logic [3:0] d);
    return {m16(a[7:4], d), m16(a[7:4] ^ a[3:0], d)};
  endfunction

  task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit later, score transfers.
  task automatic step(input logic v, input logic [7:0] a, input logic [3:0] d,
                      input logic [TAG_W-1:0] t, input logic r,
                      output logic acc, output logic got);
    exp_t e;
    @(negedge clk);
    in_valid = v; in_a = a; in_d = d; in_tag = t; out_ready = r;
    #1;
    if (stall_prev) begin
      chk(out_valid && out_inv == hold_inv && out_tag == hold_tag, "stall_hold",
          {out_valid, 15'd0, 4'd0, out_tag, out_inv}, {1'b1, 15'd0, 4'd0, hold_tag, hold_inv});
    end
    got = out_valid & out_ready;
    acc = in_valid & in_ready;
    if (got) begin
      if (exp_q.size() == 0) begin
        chk(1'b0, "spurious_out", {24'd0, out_inv}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk(out_inv == e.inv, "out_inv", {24'd0, out_inv}, {24'd0, e.inv});
        chk(out_tag == e.tag, "out_tag", {28'd0, out_tag}, {28'd0, e.tag});
      end
    end
    if (acc) begin
      e.inv = ref_inv(a, d);
      e.tag = t;
      exp_q.push_back(e);
    end
    stall_prev = out_valid & ~out_ready;
    hold_inv   = out_inv;
    hold_tag   = out_tag;
  endtask

  task automatic drain();
    logic acc, got;
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step(1'b0, 8'h00, 4'h0, '0, 1'b1, acc, got);
      n++;
    end
    chk(exp_q.size() == 0, "drain_timeout", exp_q.size(), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    logic acc, got;
    int   lat, nacc, nout, idx;
    logic v_r;
    logic [7:0] a_r;
    logic [3:0] d_r;
    logic [TAG_W-1:0] t_r;

    vecs[0] = '{8'h01, 4'h1, 8'h01};
    vecs[1] = '{8'h10, 4'h4, 8'h44};
    vecs[2] = '{8'h23, 4'h2, 8'h32};
    vecs[3] = '{8'h40, 4'h4, 8'h66};
    vecs[4] = '{8'h00, 4'h0, 8'h00};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_d = '0; in_tag = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk(in_ready == 1'b1, "rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk(out_valid == 1'b0, "rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk(busy == 1'b0, "rst_busy", {31'd0, busy}, 32'd0);
    chk(out_inv == 8'h00 && out_tag == '0, "rst_out_data", {20'd0, out_tag, out_inv}, 32'd0);

    // Single ops: latency 2 and table value
    foreach (vecs[i]) begin
      step(1'b1, vecs[i].a, vecs[i].d, TAG_W'(i), 1'b1, acc, got);
      chk(acc, "single_accept", {31'd0, acc}, 32'd1);
      lat = 0; got = 1'b0;
      while (!got && lat < 8) begin
        step(1'b0, 8'h00, 4'h0, '0, 1'b1, acc, got);
        lat++;
      end
      chk(lat == 2, "single_latency", lat, 32'd2);
      chk(out_inv == vecs[i].exp, "single_table", {24'd0, out_inv}, {24'd0, vecs[i].exp});
    end

    // Streaming: 5 back-to-back, results on cycles 2..6
    for (int c = 0; c < 7; c++) begin
      if (c < 5) begin
        step(1'b1, vecs[c].a, vecs[c].d, TAG_W'(c + 1), 1'b1, acc, got);
        chk(acc, "stream_in_ready", {31'd0, acc}, 32'd1);
      end else begin
        step(1'b0, 8'h00, 4'h0, '0, 1'b1, acc, got);
      end
      chk(got == (c >= 2), "stream_out_cycle", {31'd0, got}, {31'd0, c >= 2});
      if (got) chk(out_tag == TAG_W'(c - 1), "stream_tag", {28'd0, out_tag}, c - 1);
    end

    // Backpressure: out_ready low, only 2 accepted, output held
    nacc = 0; idx = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, vecs[idx].a, vecs[idx].d, TAG_W'(idx + 1), 1'b0, acc, got);
      if (acc) begin nacc++; idx++; end
    end
    chk(nacc == 2, "bp_accepts", nacc, 32'd2);
    chk(out_valid && out_inv == 8'h01, "bp_hold_value", {23'd0, out_valid, out_inv}, {23'd0, 1'b1, 8'h01});
    nout = 0;
    for (int c = 0; c < 30 && (idx < 5 || exp_q.size() != 0); c++) begin
      if (idx < 5) step(1'b1, vecs[idx].a, vecs[idx].d, TAG_W'(idx + 1), 1'b1, acc, got);
      else         step(1'b0, 8'h00, 4'h0, '0, 1'b1, acc, got);
      if (acc) idx++;
      if (got) nout++;
    end
    chk(nout == 5 && exp_q.size() == 0, "bp_drain_count", nout, 32'd5);

    // Reset mid-flight with two operands held in the pipe
    step(1'b1, 8'h23, 4'h2, 4'd7, 1'b0, acc, got);
    step(1'b1, 8'h40, 4'h4, 4'd8, 1'b0, acc, got);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk(out_valid == 1'b0, "rst_cycle_no_xfer", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk(out_valid == 1'b0 && busy == 1'b0 && in_ready == 1'b1, "midrst_flags",
        {29'd0, out_valid, busy, in_ready}, 32'd1);
    chk(out_inv == 8'h00, "midrst_out_inv", {24'd0, out_inv}, 32'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    nout = 0;
    for (int c = 0; c < 6; c++) begin
      step(1'b0, 8'h00, 4'h0, '0, 1'b1, acc, got);
      if (got) nout++;
    end
    chk(nout == 0, "midrst_no_stale", nout, 32'd0);

    // Random traffic; a pending operand is held until accepted
    v_r = 1'b0; a_r = '0; d_r = '0; t_r = '0;
    for (int c = 0; c < 10000; c++) begin
      if (!v_r) begin
        v_r = ($urandom_range(0, 3) != 0);
        a_r = 8'($urandom); d_r = 4'($urandom); t_r = TAG_W'($urandom);
      end
      step(v_r, a_r, d_r, t_r, 1'($urandom_range(0, 3) != 0), acc, got);
      if (acc) v_r = 1'b0;
    end
    drain();

    // Exhaustive A x D
    for (int p = 0; p < 4096; p++) begin
      acc = 1'b0;
      for (int w = 0; w < 4 && !acc; w++)
        step(1'b1, 8'(p >> 4), 4'(p), TAG_W'(p), 1'b1, acc, got);
      if (!acc) chk(1'b0, "exh_accept_timeout", p, 32'd0);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pprm_stage_3_pipe.md
Name: pprm_stage_3_pipe

Overview:
Final stage of the 3-stage PPRM GF(2^8) inverter, directly downstream of stage 2 (the GF(2^4) inverter that produces D from C). It takes the original tower-field byte A and D = inv(Δ), and forms the two GF(2^4) products that give the inverse: out_h = A_h·D, out_l = (A_h⊕A_l)·D. The block is a two-register valid/ready pipeline with full throughput and backpressure, and it carries a sideband tag, so the S-box datapath can be pipelined with stall support.

Parameters:
TAG_W, 4, width of the opaque sideband tag carried alongside each operand (legal range 1..16).

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, synchronous and active-high
in_valid  input  1  upstream holds a valid operand
in_ready  output  1  block accepts an operand this cycle
in_a  input  8  tower-field byte A: [7:4]=A_h, [3:0]=A_l
in_d  input  4  stage-2 output D = inv(Δ) in GF(2^4)
in_tag  input  TAG_W  sideband tag, returned unchanged
out_valid  output  1  out_inv/out_tag hold a valid result
out_ready  input  1  downstream accepts the result this cycle
out_inv  output  8  inverse: [7:4]=A_h·D, [3:0]=(A_h⊕A_l)·D
out_tag  output  TAG_W  tag of the result on out_inv
busy  output  1  high when either pipeline register holds data

Behaviour:
- Field arithmetic (fixed):
  - GF(4) element {p1,p0} = p1·ω+p0, with ω²=ω+1.
  - GF(4) multiply: r1 = p1q1⊕p1q0⊕p0q1; r0 = p1q1⊕p0q0.
  - Multiply by φ=ω: {p1,p0} -> {p1⊕p0, p1}.
  - GF(16) element {a1,a0}: a1 = bits[3:2], a0 = bits[1:0], value a1·y+a0, with y² = y+φ.
  - GF(16) multiply: high = a1b1⊕a1b0⊕a0b1; low = φ·(a1b1)⊕a0b0.
- Pipeline:
  - S1 register: holds in_a, in_d, in_tag, s1_valid.
  - S2 register: holds out_inv, out_tag, out_valid. The products are computed combinationally from S1 and registered into S2.
- Handshake:
  - adv2 = s1_valid & (~out_valid | out_ready).
  - in_ready = ~s1_valid | adv2. This ready path is combinational.
  - Input transfer occurs on in_valid & in_ready. Output transfer occurs on out_valid & out_ready.
  - While out_valid=1 and out_ready=0, out_inv and out_tag hold stable.
  - No bubbles: one transfer per cycle sustained when out_ready=1.
- Latency: 2 cycles from input transfer to out_valid, with no stall.
- Simultaneous events: in the same cycle, S2 may drain, S1 may move into S2, and a new input may load S1; no data is lost or duplicated.
- Zero: A=0x00 with D=0x0 gives out_inv=0x00 (inherent, no special case).
- busy = s1_valid | out_valid.
- Reset:
  - Clears s1_valid and out_valid to 0, and sets out_inv to 0x00 and out_tag to 0.
  - in_ready reads 1 in the first cycle after reset.
  - busy is 0 after reset.
  - Reset asserted mid-operation discards all in-flight data; no output transfer occurs in the reset cycle.
- Inputs are ignored when in_ready=0. Upstream must hold in_a, in_d and in_tag stable while in_valid=1 and in_ready=0.

Test Plan:
- Single ops, out_ready=1. Each must produce out_valid exactly 2 cycles after acceptance:
  - A=0x01, D=0x1 -> 0x01
  - A=0x10, D=0x4 -> 0x44
  - A=0x23, D=0x2 -> 0x32
  - A=0x40, D=0x4 -> 0x66
  - A=0x00, D=0x0 -> 0x00
- Streaming: present the 5 vectors above back-to-back with tags 1..5 and out_ready=1 -> 5 results on 5 consecutive cycles, in order, tags matching; in_ready stays 1 throughout.
- Backpressure: hold out_ready=0 while streaming.
  - in_ready drops after 2 accepts; out_inv holds 0x01 stable.
  - When out_ready is released, results drain in order with no loss or duplication.
- Random: 10k random (A, D, tag) triples with random in_valid/out_ready -> output matches a GF reference model; tag order is preserved.
- Reset mid-flight: with 2 operands in flight, pulse rst for 1 cycle.
  - Next cycle: out_valid=0, busy=0, in_ready=1, out_inv=0x00.
  - No stale result appears afterwards.
- Exhaustive: all 4096 (A, D) pairs -> out_inv matches the reference multiply model.
